dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder at the far end of the core's load/store control path.
- Consumes the decoder's mem_r/mem_w intent together with func3, address and store data.
- Performs byte/half/word/double accesses on an internal doubleword RAM after a programmable wait.
- Returns sign- or zero-extended load data, or an error flag, through a valid/ready response handshake.

Parameters:
DEPTH, 1024, RAM size in 64-bit doublewords
LATENCY, 2, wait cycles between request accept and response (legal range 1..15)
ADDR_BASE, 64'h8000_0000, byte address mapped to RAM doubleword 0

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request; high only in IDLE
mem_r  input  1  load request
mem_w  input  1  store request
func3  input  3  RISC-V load/store funct3 (size in [1:0], unsigned flag in [2])
addr  input  64  byte address
wdata  input  64  store data, LSB-aligned
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rdata  output  64  extended load data; 0 for stores and errors
rsp_err  output  1  request was rejected: misaligned, out of range, or illegal

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rdata=0, rsp_err=0, wait counter=0. RAM contents are not reset.
- Reset mid-operation aborts the transaction. A store that has not reached the WAIT exit edge never modifies RAM.
- FSM states are IDLE, WAIT and RESP. req_ready is asserted combinationally when state==IDLE.
- Accept: on a rising edge with state==IDLE, req_valid=1 and (mem_r|mem_w)=1, capture mem_r, mem_w, func3, addr and wdata.
- A handshake with mem_r=mem_w=0 is dropped: no state change and no response.
- Size decode: func3[1:0] gives size 0=B, 1=H, 2=W, 3=D.
- Error checks on captured values (error takes priority; the RAM is never touched on error):
  - mem_r and mem_w both set.
  - Store with func3[2]=1.
  - Load with func3=3'b111.
  - Misaligned address: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0.
  - addr<ADDR_BASE, or (addr-ADDR_BASE)>=DEPTH*8.
- Error path: IDLE goes to RESP on the accept edge itself, so rsp_valid is high the following cycle, with rsp_err=1 and rdata=0.
- Legal path: IDLE goes to WAIT on the accept edge, loading the counter with LATENCY-1.
  - On each edge in WAIT with counter≠0, the counter decrements.
  - On the edge where counter==0, the access is performed and state goes to RESP. rsp_valid therefore rises exactly LATENCY edges after the accept edge.
- Store: index=(addr-ADDR_BASE)>>3, lane=addr[2:0]. Write the low 8/16/32/64 bits of wdata into bytes lane..lane+2^size-1 of RAM[index]. All other bytes are unchanged. rdata=0, rsp_err=0.
- Load: take RAM[index] >> (lane*8) and keep the low 8·2^size bits.
  - func3[2]=0: sign-extend to 64 bits.
  - func3[2]=1: zero-extend to 64 bits.
  - Register the result into rdata with rsp_err=0.
- RESP: rsp_valid, rdata and rsp_err are held stable until an edge with rsp_ready=1. On that edge, rsp_valid goes to 0, rdata and rsp_err go to 0, and state goes to IDLE.
- No request is accepted in the same edge as a response retires. Minimum issue interval is LATENCY+2 cycles.
- Inputs are ignored outside IDLE, and req_valid may stay high without side effects.

Test Plan:
- Reset behaviour: reset asserted then released → req_ready=1, rsp_valid=0, rdata=0, rsp_err=0.
- Store/load round trip, double: SD wdata=64'h1122_3344_5566_7788 at addr 0x8000_0010 → rsp_valid exactly 2 edges after accept with rsp_err=0. Then LD at the same address → rdata=64'h1122_3344_5566_7788.
- Sub-word merge and extension:
  - After the double store above, SB 8'hF0 at 0x8000_0013, then LW 0x8000_0010 → rdata=64'h0000_0000_F066_7788 sign-extended, i.e. 64'hFFFF_FFFF_F066_7788.
  - LWU at the same address → 64'h0000_0000_F066_7788.
  - LBU at 0x8000_0013 → 64'h0000_0000_0000_00F0.
- Error cases:
  - LH at 0x8000_0001 → rsp_err=1 one cycle after accept, rdata=0.
  - SD at 0x8000_2000 (out of range at DEPTH=1024) → rsp_err=1, and a subsequent LD at 0x8000_0000 returns the prior value unchanged.
  - mem_r=mem_w=1 → rsp_err=1.
- Response backpressure: hold rsp_ready=0 for 5 cycles during a response → rsp_valid, rdata and rsp_err stay constant and req_ready=0. Raise rsp_ready → one-edge retire, then req_ready=1.
- Reset mid-operation: SW 32'hDEAD_BEEF accepted, rst_n pulsed low during WAIT, then LW at the same address → old value returned and the response from the aborted store never appears.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the load/store control path and dmem_responder.
// The responder side also publishes its FSM state for observation.
interface dmem_responder_if;
    // Both channels complete on a rising edge where valid and ready are high together;
    // a producer holds valid and payload stable until then, and ready never depends on valid.
    logic        req_valid;
    logic        req_ready;
    logic        mem_r;
    logic        mem_w;
    logic [2:0]  func3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rdata;
    logic        rsp_err;
    logic [1:0]  dbg_state;

    modport master (
        output req_valid, mem_r, mem_w, func3, addr, wdata, rsp_ready,
        input  req_ready, rsp_valid, rdata, rsp_err, dbg_state
    );

    modport slave (
        input  req_valid, mem_r, mem_w, func3, addr, wdata, rsp_ready,
        output req_ready, rsp_valid, rdata, rsp_err, dbg_state
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: byte/half/word/double loads and stores on an
// internal doubleword RAM, answered after a fixed wait through a valid/ready response.
module dmem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] ADDR_BASE = 64'h8000_0000
) (
    input logic             clk,
    input logic             rst_n,
    dmem_responder_if.slave bus
);

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] RANGE     = 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  WAIT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic             cap_r;
    logic             cap_w;
    logic [2:0]       cap_f3;
    logic [IDX_W-1:0] cap_idx;
    logic [2:0]       cap_lane;
    logic [63:0]      cap_wdata;
    logic [63:0]      rdata_q;
    logic             err_q;

    logic [63:0] mem [DEPTH];

    // ---------------- request decode on live inputs ----------------
    logic [63:0] req_off;
    logic        in_range;
    logic        misaligned;
    logic        illegal;
    logic        req_err;
    logic        accept;

    assign req_off  = bus.addr - ADDR_BASE;
    assign in_range = (bus.addr >= ADDR_BASE) && (req_off < RANGE);

    always_comb begin
        misaligned = 1'b0;
        case (bus.func3[1:0])
            2'd1:    misaligned = bus.addr[0];
            2'd2:    misaligned = |bus.addr[1:0];
            2'd3:    misaligned = |bus.addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign illegal = (bus.mem_r && bus.mem_w)
                   || (bus.mem_w && bus.func3[2])
                   || (bus.mem_r && (bus.func3 == 3'b111));
    assign req_err = illegal || misaligned || !in_range;
    assign accept  = (state == S_IDLE) && bus.req_valid && (bus.mem_r || bus.mem_w);

    // ---------------- access datapath on captured request ----------------
    logic [5:0]  shift;
    logic [63:0] size_mask;
    logic [63:0] word;
    logic [63:0] wr_mask;
    logic [63:0] wr_data;
    logic [63:0] merged;
    logic [63:0] ld_raw;
    logic        ld_sign;
    logic [63:0] ld_ext;
    logic        do_access;

    assign shift = {cap_lane, 3'b000};

    always_comb begin
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (cap_f3[1:0])
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign word    = mem[cap_idx];
    assign wr_mask = size_mask << shift;
    assign wr_data = cap_wdata << shift;
    assign merged  = (word & ~wr_mask) | (wr_data & wr_mask);
    assign ld_raw  = (word >> shift) & size_mask;

    always_comb begin
        ld_sign = 1'b0;
        case (cap_f3[1:0])
            2'd0:    ld_sign = ld_raw[7];
            2'd1:    ld_sign = ld_raw[15];
            2'd2:    ld_sign = ld_raw[31];
            default: ld_sign = 1'b0;
        endcase
    end

    // Doubleword loads have no bits above the field, so the sign flag is irrelevant there.
    assign ld_ext    = (ld_sign && !cap_f3[2]) ? (ld_raw | ~size_mask) : ld_raw;
    assign do_access = (state == S_WAIT) && (cnt == 4'd0);

    // RAM is deliberately not reset; state is IDLE throughout reset so no write can slip in.
    always_ff @(posedge clk) begin
        if (do_access && cap_w) begin
            mem[cap_idx] <= merged;
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            cap_r     <= 1'b0;
            cap_w     <= 1'b0;
            cap_f3    <= 3'd0;
            cap_idx   <= '0;
            cap_lane  <= 3'd0;
            cap_wdata <= 64'd0;
            rdata_q   <= 64'd0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cap_r     <= bus.mem_r;
                        cap_w     <= bus.mem_w;
                        cap_f3    <= bus.func3;
                        cap_idx   <= req_off[IDX_W+2:3];
                        cap_lane  <= bus.addr[2:0];
                        cap_wdata <= bus.wdata;
                        if (req_err) begin
                            state   <= S_RESP;
                            rdata_q <= 64'd0;
                            err_q   <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state   <= S_RESP;
                        rdata_q <= cap_r ? ld_ext : 64'd0;
                        err_q   <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state   <= S_IDLE;
                        rdata_q <= 64'd0;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rdata     = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a driver queues expected responses, a monitor
// retires them as the DUT presents them, then prints one summary line.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   seen = 1'b0;

    logic [63:0] exp_q[$];
    logic        err_q[$];
    int          lat_q[$];
    int          drv_q[$];

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH    (1024),
        .LATENCY  (LAT),
        .ADDR_BASE(64'h8000_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (bus.req_ready && !bus.rsp_valid) return;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL wait_idle: got busy expected idle");
    endtask

    task automatic issue(input logic r, input logic w, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] exp_rd, input logic exp_err, input bit push);
        wait_idle();
        if (push) begin
            exp_q.push_back(exp_rd);
            err_q.push_back(exp_err);
            lat_q.push_back(exp_err ? 1 : LAT + 1);
            drv_q.push_back(cyc);
        end
        bus.mem_r     = r;
        bus.mem_w     = w;
        bus.func3     = f3;
        bus.addr      = a;
        bus.wdata     = wd;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_r     = 1'b0;
        bus.mem_w     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_rdata"},     bus.rdata,          64'd0);
        chk({tag, "_rsp_err"},   64'(bus.rsp_err),   64'd0);
        chk({tag, "_state"},     64'(bus.dbg_state), 64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (bus.rsp_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rdata=%h err=%b expected no response",
                         bus.rdata, bus.rsp_err);
            end else begin
                chk("rsp_rdata",   bus.rdata,                 exp_q.pop_front());
                chk("rsp_err",     64'(bus.rsp_err),          64'(err_q.pop_front()));
                chk("rsp_latency", 64'(cyc - drv_q.pop_front()), 64'(lat_q.pop_front()));
            end
        end else if (!bus.rsp_valid) begin
            seen = 1'b0;
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bus.req_valid = 1'b0;
        bus.mem_r     = 1'b0;
        bus.mem_w     = 1'b0;
        bus.func3     = 3'd0;
        bus.addr      = 64'd0;
        bus.wdata     = 64'd0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // SD / LD round trip, then sub-word merge and extension
        issue(0, 1, 3'b011, 64'h8000_0010, 64'h1122_3344_5566_7788, 64'd0, 0, 1);
        issue(1, 0, 3'b011, 64'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 0, 1);
        issue(0, 1, 3'b000, 64'h8000_0013, 64'hABCD_00F0, 64'd0, 0, 1);
        issue(1, 0, 3'b010, 64'h8000_0010, 64'd0, 64'hFFFF_FFFF_F066_7788, 0, 1);
        issue(1, 0, 3'b110, 64'h8000_0010, 64'd0, 64'h0000_0000_F066_7788, 0, 1);
        issue(1, 0, 3'b100, 64'h8000_0013, 64'd0, 64'h0000_0000_0000_00F0, 0, 1);
        issue(1, 0, 3'b000, 64'h8000_0013, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 0, 1);
        issue(1, 0, 3'b001, 64'h8000_0016, 64'd0, 64'h0000_0000_0000_1122, 0, 1);
        issue(1, 0, 3'b101, 64'h8000_0012, 64'd0, 64'h0000_0000_0000_F066, 0, 1);
        issue(1, 0, 3'b000, 64'h8000_0012, 64'd0, 64'h0000_0000_0000_0066, 0, 1);

        // last doubleword of the RAM is in range
        issue(0, 1, 3'b011, 64'h8000_1FF8, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 1);
        issue(1, 0, 3'b011, 64'h8000_1FF8, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 1);

        // error cases; the out-of-range SD would alias doubleword 0 if not rejected
        issue(0, 1, 3'b011, 64'h8000_0000, 64'hCAFE_BABE_0BAD_F00D, 64'd0, 0, 1);
        issue(1, 0, 3'b001, 64'h8000_0001, 64'd0, 64'd0, 1, 1);
        issue(0, 1, 3'b011, 64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 1);
        issue(1, 0, 3'b011, 64'h8000_0000, 64'd0, 64'hCAFE_BABE_0BAD_F00D, 0, 1);
        issue(1, 1, 3'b011, 64'h8000_0000, 64'd0, 64'd0, 1, 1);
        issue(1, 0, 3'b011, 64'h7FFF_FFF8, 64'd0, 64'd0, 1, 1);
        issue(0, 1, 3'b100, 64'h8000_0000, 64'h55, 64'd0, 1, 1);
        issue(1, 0, 3'b111, 64'h8000_0000, 64'd0, 64'd0, 1, 1);
        issue(1, 0, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 1, 1);
        issue(1, 0, 3'b011, 64'h8000_0000, 64'd0, 64'hCAFE_BABE_0BAD_F00D, 0, 1);

        // handshake with neither mem_r nor mem_w is dropped
        issue(0, 0, 3'b011, 64'h8000_0000, 64'd0, 64'd0, 0, 0);
        chk("dropped_req_ready", 64'(bus.req_ready), 64'd1);
        repeat (4) @(negedge clk);

        // response backpressure
        bus.rsp_ready = 1'b0;
        issue(1, 0, 3'b011, 64'h8000_0010, 64'd0, 64'h1122_3344_F066_7788, 0, 1);
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid) break;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_rdata",     bus.rdata,          64'h1122_3344_F066_7788);
            chk("bp_rsp_err",   64'(bus.rsp_err),   64'd0);
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("retire_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("retire_req_ready", 64'(bus.req_ready), 64'd1);
        chk("retire_rdata",     bus.rdata,          64'd0);

        // reset during WAIT aborts the store
        issue(0, 1, 3'b010, 64'h8000_0010, 64'hDEAD_BEEF, 64'd0, 0, 0);
        chk("mid_state_wait", 64'(bus.dbg_state), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(1, 0, 3'b010, 64'h8000_0010, 64'd0, 64'hFFFF_FFFF_F066_7788, 0, 1);

        wait_idle();
        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
